// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types, defaults and helpers for the SPI shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default word length for the shift register and its bus interface
    localparam int c_DATA_WIDTH = 8;

    // Shift-register control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Map a running bit count onto a word bit position for the chosen order
    function automatic logic [15:0] bit_index(input logic [15:0] cnt,
                                              input logic        lsbfe,
                                              input logic [15:0] width);
        return lsbfe ? cnt : (width - 16'd1 - cnt);
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shift_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_register_if
//  Description : Bus bundle between the SPI control/baud logic (master side)
//                and the serialiser/deserialiser (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_shift_register_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
);
    logic                  ss_i;
    logic                  send_data_i;
    logic                  lsbfe_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic [DATA_WIDTH-1:0] data_mosi_i;
    logic                  miso_i;
    logic                  mosi_send_sclk_i;
    logic                  mosi_send_sclk0_i;
    logic                  miso_receive_sclk_i;
    logic                  miso_receive_sclk0_i;
    logic                  mosi_o;
    logic [DATA_WIDTH-1:0] data_miso_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output ss_i, send_data_i, lsbfe_i, cpol_i, cpha_i, data_mosi_i, miso_i,
        output mosi_send_sclk_i, mosi_send_sclk0_i,
        output miso_receive_sclk_i, miso_receive_sclk0_i,
        input  mosi_o, data_miso_o, busy_o, done_o
    );

    modport slave (
        input  ss_i, send_data_i, lsbfe_i, cpol_i, cpha_i, data_mosi_i, miso_i,
        input  mosi_send_sclk_i, mosi_send_sclk0_i,
        input  miso_receive_sclk_i, miso_receive_sclk0_i,
        output mosi_o, data_miso_o, busy_o, done_o
    );

endinterface : spi_shift_register_if
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bit_counter
//  Description : Bit counter with synchronous clear, count enable and a flag
//                raised while the count equals TERMINAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_counter #(
    parameter int CNT_W    = 4,
    parameter int TERMINAL = 8
) (
    input  wire logic             PCLK,
    input  wire logic             PRESET_n,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output      logic [CNT_W-1:0] o_cnt,
    output      logic             o_term
);

    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over enable so an abort and a flag in the same cycle restart at zero
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == c_TERM);

endmodule : spi_bit_counter
`default_nettype wire

// File: rtl/spi_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_register
//  Description : Serialises one word onto MOSI and deserialises MISO, driven by
//                the baud generator's edge flags, for all CPOL/CPHA modes and
//                either bit order. Pulses done_o on word completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int CNT_W      = 4
) (
    input  wire logic           PCLK,
    input  wire logic           PRESET_n,
    spi_shift_register_if.slave bus
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                r_state;
    logic                  r_lsbfe;
    logic                  r_cpol;
    logic                  r_cpha;
    logic [DATA_WIDTH-1:0] r_tx_word;
    logic [DATA_WIDTH-1:0] r_rx_word;
    logic                  r_mosi;
    logic [DATA_WIDTH-1:0] r_data_miso;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_sel;
    logic                  w_send_flag;
    logic                  w_recv_flag;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_tx_fire;
    logic                  w_rx_fire;
    logic                  w_cnt_clr;
    logic [CNT_W-1:0]      w_tx_cnt;
    logic [CNT_W-1:0]      w_rx_cnt;
    logic                  w_tx_term;
    logic                  w_rx_term;
    logic [IDX_W-1:0]      w_tx_idx;
    logic [IDX_W-1:0]      w_rx_idx;
    logic [DATA_WIDTH-1:0] w_rx_next;

    // Modes 1 and 2 act on the sclk0 flags; the latched mode is used so that
    // mode pins changing mid-word cannot switch flag sets
    assign w_sel       = r_cpol ^ r_cpha;
    assign w_send_flag = w_sel ? bus.mosi_send_sclk0_i    : bus.mosi_send_sclk_i;
    assign w_recv_flag = w_sel ? bus.miso_receive_sclk0_i : bus.miso_receive_sclk_i;

    assign w_start   = (r_state == ST_IDLE)   &&  bus.send_data_i && !bus.ss_i;
    assign w_abort   = (r_state == ST_ACTIVE) &&  bus.ss_i;
    assign w_tx_fire = (r_state == ST_ACTIVE) && !bus.ss_i && w_send_flag && !w_tx_term;
    assign w_rx_fire = (r_state == ST_ACTIVE) && !bus.ss_i && w_recv_flag;
    assign w_cnt_clr = w_start || w_abort;

    spi_bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (DATA_WIDTH)
    ) u_tx_cnt (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_tx_fire),
        .o_cnt    (w_tx_cnt),
        .o_term   (w_tx_term)
    );

    // Terminal at the last bit position: the flag that samples it finishes the word
    spi_bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (DATA_WIDTH - 1)
    ) u_rx_cnt (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_rx_fire),
        .o_cnt    (w_rx_cnt),
        .o_term   (w_rx_term)
    );

    assign w_tx_idx = IDX_W'(bit_index(16'(w_tx_cnt), r_lsbfe, 16'(DATA_WIDTH)));
    assign w_rx_idx = IDX_W'(bit_index(16'(w_rx_cnt), r_lsbfe, 16'(DATA_WIDTH)));

    // Receive word including the bit sampled this cycle, so the final bit
    // reaches data_miso_o on the same edge that completes the word
    always_comb begin
        w_rx_next           = r_rx_word;
        w_rx_next[w_rx_idx] = bus.miso_i;
    end

    // Control FSM with registered outputs and the tx/rx word registers
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state     <= ST_IDLE;
            r_lsbfe     <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_tx_word   <= '0;
            r_rx_word   <= '0;
            r_mosi      <= 1'b0;
            r_data_miso <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_tx_word <= bus.data_mosi_i;
                        r_lsbfe   <= bus.lsbfe_i;
                        r_cpol    <= bus.cpol_i;
                        r_cpha    <= bus.cpha_i;
                        r_rx_word <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_abort) begin
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_tx_fire) begin
                            r_mosi <= r_tx_word[w_tx_idx];
                        end
                        if (w_rx_fire) begin
                            r_rx_word <= w_rx_next;
                            if (w_rx_term) begin
                                r_data_miso <= w_rx_next;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mosi_o      = r_mosi;
    assign bus.data_miso_o = r_data_miso;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;

endmodule : spi_shift_register
`default_nettype wire
